// File: rtl/axil_regbank_ctrl_if.sv
// rtl/axil_regbank_ctrl_if.sv - AXI4-Lite slave bus bundle for the register bank
interface axil_regbank_ctrl_if #(
    parameter int WIDTH = 32
);
    logic               awvalid;
    logic               awready;
    logic [2:0]         awaddr;
    logic               wvalid;
    logic               wready;
    logic [WIDTH-1:0]   wdata;
    logic [WIDTH/8-1:0] wstrb;
    logic               bvalid;
    logic               bready;
    logic [1:0]         bresp;
    logic               arvalid;
    logic               arready;
    logic [2:0]         araddr;
    logic               rvalid;
    logic               rready;
    logic [WIDTH-1:0]   rdata;
    logic [1:0]         rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axil_regbank_ctrl.sv
// rtl/axil_regbank_ctrl.sv - AXI4-Lite 8-entry register bank; optional wr_pulse via AXIL_REGBANK_WR_PULSE_EN
module axil_regbank_ctrl #(
    parameter int               WIDTH     = 32,
    parameter logic [7:0]       RO_MASK   = 8'h00,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    axil_regbank_ctrl_if.slave   bus,
    output logic [8*WIDTH-1:0]   regs_o
`ifdef AXIL_REGBANK_WR_PULSE_EN
    ,
    output logic [7:0]           wr_pulse
`endif
);
    localparam int NB = WIDTH / 8;

    typedef enum logic {W_COLLECT, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    wr_state_t        r_wr_state, w_wr_next;
    rd_state_t        r_rd_state, w_rd_next;

    logic             r_aw_held, r_w_held;
    logic [2:0]       r_awaddr;
    logic [WIDTH-1:0] r_wdata;
    logic [NB-1:0]    r_wstrb;
    logic [1:0]       r_bresp;
    logic [WIDTH-1:0] r_rdata;
    logic [WIDTH-1:0] r_regs [8];

    logic             w_awready, w_wready, w_bvalid;
    logic             w_aw_hs, w_w_hs, w_commit;
    logic             w_arready, w_rvalid, w_ar_hs;
    logic [2:0]       w_cm_addr;
    logic [WIDTH-1:0] w_cm_data;
    logic [NB-1:0]    w_cm_strb;
    logic             w_cm_ro;

    // A handshake landing on the commit edge has not been latched yet, so take it straight from the bus.
    assign w_cm_addr = r_aw_held ? r_awaddr : bus.awaddr;
    assign w_cm_data = r_w_held  ? r_wdata  : bus.wdata;
    assign w_cm_strb = r_w_held  ? r_wstrb  : bus.wstrb;
    assign w_cm_ro   = RO_MASK[w_cm_addr];

    assign bus.awready = w_awready;
    assign bus.wready  = w_wready;
    assign bus.bvalid  = w_bvalid;
    assign bus.bresp   = r_bresp;
    assign bus.arready = w_arready;
    assign bus.rvalid  = w_rvalid;
    assign bus.rdata   = r_rdata;
    assign bus.rresp   = 2'b00;

    // Write FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_wr_state <= W_COLLECT;
        else     r_wr_state <= w_wr_next;
    end

    // Write FSM next state, ready/valid outputs and commit detection.
    always_comb begin
        w_wr_next = r_wr_state;
        w_awready = 1'b0;
        w_wready  = 1'b0;
        w_bvalid  = 1'b0;
        w_aw_hs   = 1'b0;
        w_w_hs    = 1'b0;
        w_commit  = 1'b0;
        case (r_wr_state)
            W_COLLECT: begin
                w_awready = !r_aw_held;
                w_wready  = !r_w_held;
                w_aw_hs   = bus.awvalid && w_awready;
                w_w_hs    = bus.wvalid && w_wready;
                w_commit  = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
                if (w_commit) w_wr_next = W_RESP;
            end
            W_RESP: begin
                w_bvalid = 1'b1;
                if (bus.bready) w_wr_next = W_COLLECT;
            end
            default: w_wr_next = W_COLLECT;
        endcase
    end

    // Address/data capture, byte-strobe commit into the bank and write response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bresp   <= 2'b00;
            for (int i = 0; i < 8; i++) r_regs[i] <= RESET_VAL;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_awaddr  <= bus.awaddr;
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= bus.wdata;
                r_wstrb  <= bus.wstrb;
            end
            if (w_commit) begin
                r_bresp <= w_cm_ro ? 2'b10 : 2'b00;
                if (!w_cm_ro) begin
                    for (int b = 0; b < NB; b++) begin
                        if (w_cm_strb[b]) r_regs[w_cm_addr][b*8 +: 8] <= w_cm_data[b*8 +: 8];
                    end
                end
            end
            if (w_bvalid && bus.bready) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_rd_state <= R_IDLE;
        else     r_rd_state <= w_rd_next;
    end

    // Read FSM next state and ready/valid outputs.
    always_comb begin
        w_rd_next = r_rd_state;
        w_arready = 1'b0;
        w_rvalid  = 1'b0;
        w_ar_hs   = 1'b0;
        case (r_rd_state)
            R_IDLE: begin
                w_arready = 1'b1;
                w_ar_hs   = bus.arvalid;
                if (w_ar_hs) w_rd_next = R_DATA;
            end
            R_DATA: begin
                w_rvalid = 1'b1;
                if (bus.rready) w_rd_next = R_IDLE;
            end
            default: w_rd_next = R_IDLE;
        endcase
    end

    // Read data capture; sees the bank before any write committing on the same edge.
    always_ff @(posedge clk) begin
        if (rst)          r_rdata <= '0;
        else if (w_ar_hs) r_rdata <= r_regs[bus.araddr];
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_flat
            assign regs_o[gi*WIDTH +: WIDTH] = r_regs[gi];
        end
    endgenerate

`ifdef AXIL_REGBANK_WR_PULSE_EN
    logic [7:0] r_wr_pulse;

    // One-cycle strobe after an OKAY commit that actually touched bytes.
    always_ff @(posedge clk) begin
        if (rst)
            r_wr_pulse <= 8'h00;
        else if (w_commit && !w_cm_ro && (w_cm_strb != '0))
            r_wr_pulse <= 8'h01 << w_cm_addr;
        else
            r_wr_pulse <= 8'h00;
    end

    assign wr_pulse = r_wr_pulse;
`endif
endmodule

// File: tb/tb_axil_regbank_ctrl.sv
// tb/tb_axil_regbank_ctrl.sv - self-checking bench for axil_regbank_ctrl
module tb_axil_regbank_ctrl;
    localparam int         WIDTH = 32;
    localparam logic [7:0] RO    = 8'h04;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [8*WIDTH-1:0] regs_o;
`ifdef AXIL_REGBANK_WR_PULSE_EN
    logic [7:0] wr_pulse;
`endif

    axil_regbank_ctrl_if #(.WIDTH(WIDTH)) bus ();

    axil_regbank_ctrl #(
        .WIDTH(WIDTH),
        .RO_MASK(RO),
        .RESET_VAL(32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .regs_o(regs_o)
`ifdef AXIL_REGBANK_WR_PULSE_EN
        ,
        .wr_pulse(wr_pulse)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] m_regs [8];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] model_flat();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = m_regs[i];
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 32'h0;
    endfunction

    function automatic void model_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s,
                                        output logic [1:0] resp, output logic [7:0] pulse);
        logic [31:0] mask;
        mask = 32'h0;
        for (int b = 0; b < 4; b++) if (s[b]) mask = mask | (32'hFF << (8 * b));
        if (RO[a]) begin
            resp  = 2'b10;
            pulse = 8'h00;
        end else begin
            resp      = 2'b00;
            m_regs[a] = (m_regs[a] & ~mask) | (d & mask);
            pulse     = (s != 4'h0) ? (8'h01 << a) : 8'h00;
        end
    endfunction

    task automatic check_pulse(input string tag, input logic [7:0] exp);
`ifdef AXIL_REGBANK_WR_PULSE_EN
        check(tag, wr_pulse, exp);
`endif
    endtask

    // Called and returns at a negedge.
    task automatic axi_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int bstall);
        bit aw_done, w_done, aw_fire, w_fire;
        int cyc;
        logic [1:0] resp;
        logic [7:0] pulse;
        aw_done = 0; w_done = 0; cyc = 0;
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s; bus.bready = 1'b0;
        while (!(aw_done && w_done) && cyc < 20) begin
            bus.awvalid = !aw_done && (cyc >= aw_dly);
            bus.wvalid  = !w_done && (cyc >= w_dly);
            aw_fire = bus.awvalid && bus.awready;
            w_fire  = bus.wvalid && bus.wready;
            @(posedge clk);
            if (aw_fire) aw_done = 1;
            if (w_fire)  w_done = 1;
            cyc++;
            @(negedge clk);
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        check("wr_handshakes_done", {aw_done, w_done}, 2'b11);
        model_write(a, d, s, resp, pulse);
        check("bvalid_after_last_hs", bus.bvalid, 1'b1);
        check("bresp", bus.bresp, resp);
        check("aw_w_ready_in_resp", {bus.awready, bus.wready}, 2'b00);
        check("regs_after_commit", regs_o, model_flat());
        check_pulse("wr_pulse_after_commit", pulse);
        for (int k = 0; k < bstall; k++) begin
            @(posedge clk); @(negedge clk);
            check("bvalid_held", {bus.bvalid, bus.awready, bus.wready}, 3'b100);
            check("bresp_stable", bus.bresp, resp);
            check_pulse("wr_pulse_one_cycle", 8'h00);
        end
        bus.bready = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.bready = 1'b0;
        check("b_done_ready_back", {bus.bvalid, bus.awready, bus.wready}, 3'b011);
        check_pulse("wr_pulse_cleared", 8'h00);
    endtask

    task automatic axi_read(input logic [2:0] a, input int rstall);
        logic [31:0] exp;
        exp = m_regs[a];
        check("arready_idle", bus.arready, 1'b1);
        bus.arvalid = 1'b1; bus.araddr = a; bus.rready = 1'b0;
        @(posedge clk); @(negedge clk);
        bus.arvalid = 1'b0;
        check("rvalid_latency", {bus.rvalid, bus.arready}, 2'b10);
        check("rdata", bus.rdata, exp);
        check("rresp", bus.rresp, 2'b00);
        for (int k = 0; k < rstall; k++) begin
            @(posedge clk); @(negedge clk);
            check("rvalid_held", {bus.rvalid, bus.arready}, 2'b10);
            check("rdata_stable", bus.rdata, exp);
        end
        bus.rready = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.rready = 1'b0;
        check("r_done_arready_back", {bus.rvalid, bus.arready}, 2'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old_v;
        logic [1:0]  resp;
        logic [7:0]  pulse;
        bus.awvalid = 0; bus.awaddr = 0; bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0;
        bus.bready = 0; bus.arvalid = 0; bus.araddr = 0; bus.rready = 0;
        model_reset();
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        check("reset_readies", {bus.awready, bus.wready, bus.arready}, 3'b111);
        check("reset_valids", {bus.bvalid, bus.rvalid}, 2'b00);
        check("reset_resp_data", {bus.bresp, bus.rresp, bus.rdata}, 36'h0);
        check("reset_regs", regs_o, model_flat());
        check_pulse("reset_wr_pulse", 8'h00);

        for (int i = 0; i < 8; i++) axi_read(3'(i), 0);

        axi_write(3'd3, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        axi_read(3'd3, 0);
        axi_write(3'd5, 32'h11223344, 4'b0101, 2, 0, 0);
        check("reg5_strobed", regs_o[5*32 +: 32], 32'h00220044);
        axi_write(3'd2, 32'hFFFFFFFF, 4'hF, 1, 0, 1);
        axi_write(3'd4, 32'h55AA55AA, 4'h0, 0, 1, 0);
        axi_write(3'd1, 32'h12345678, 4'hF, 1, 1, 0);

        // Same-edge read and write to reg1 while the write response is held off.
        old_v = m_regs[1];
        bus.awvalid = 1; bus.awaddr = 3'd1; bus.wvalid = 1; bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hF;
        bus.arvalid = 1; bus.araddr = 3'd1; bus.bready = 0; bus.rready = 0;
        @(posedge clk); @(negedge clk);
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
        model_write(3'd1, 32'hCAFEF00D, 4'hF, resp, pulse);
        check("rbw_old_value", bus.rdata, old_v);
        check("rbw_valids", {bus.rvalid, bus.bvalid}, 2'b11);
        check("rbw_regs_new", regs_o, model_flat());
        check_pulse("rbw_wr_pulse", pulse);
        for (int k = 0; k < 5; k++) begin
            check("bstall_b", {bus.bvalid, bus.awready, bus.wready}, 3'b100);
            case (k)
                0: bus.rready = 1;
                1: begin
                    bus.rready = 0;
                    check("bstall_r_idle", {bus.rvalid, bus.arready}, 2'b01);
                    bus.arvalid = 1; bus.araddr = 3'd1;
                end
                2: begin
                    bus.arvalid = 0;
                    check("bstall_r_new", {bus.rvalid, bus.rdata}, {1'b1, m_regs[1]});
                    bus.rready = 1;
                end
                3: begin
                    bus.rready = 0;
                    check("bstall_r_done", bus.rvalid, 1'b0);
                end
                default: ;
            endcase
            @(posedge clk); @(negedge clk);
        end
        check("bstall_end", {bus.bvalid, bus.bresp}, 3'b100);
        bus.bready = 1;
        @(posedge clk); @(negedge clk);
        bus.bready = 0;
        check("bstall_release", {bus.bvalid, bus.awready, bus.wready}, 3'b011);

        for (int n = 0; n < 24; n++) begin
            axi_write(3'($urandom_range(7)), $urandom, 4'($urandom_range(15)),
                      $urandom_range(3), $urandom_range(3), $urandom_range(2));
            axi_read(3'($urandom_range(7)), $urandom_range(2));
        end

        // Reset while both responses are outstanding.
        bus.awvalid = 1; bus.awaddr = 3'd6; bus.wvalid = 1; bus.wdata = 32'h0BADF00D; bus.wstrb = 4'hF;
        bus.arvalid = 1; bus.araddr = 3'd6;
        @(posedge clk); @(negedge clk);
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
        model_write(3'd6, 32'h0BADF00D, 4'hF, resp, pulse);
        check("prerst_valids", {bus.bvalid, bus.rvalid}, 2'b11);
        rst = 1;
        @(posedge clk); @(negedge clk);
        rst = 0;
        model_reset();
        check("rst_valids", {bus.bvalid, bus.rvalid}, 2'b00);
        check("rst_readies", {bus.awready, bus.wready, bus.arready}, 3'b111);
        check("rst_regs", regs_o, model_flat());
        check("rst_rdata", bus.rdata, 32'h0);
        check_pulse("rst_wr_pulse", 8'h00);
        axi_read(3'd6, 0);
        axi_write(3'd7, 32'hA5A5A5A5, 4'b1001, 0, 3, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
